// File: rtl/y_sram_pkg.sv
// Shared types and constants for the Y-SRAM phase sequencer and bus arbiter.
package y_sram_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Default Y-SRAM geometry
  localparam int Y_ADDR_W = 11;
  localparam int Y_DATA_W = 256;

  // Address parked on the bus when no client owns it
  localparam logic [Y_ADDR_W-1:0] Y_IDLE_ADDR = {Y_ADDR_W{1'b1}};

  // Client phase indices in sequencing order
  localparam int PH_UPDATE_Y  = 0;
  localparam int PH_WRITE_Y   = 1;
  localparam int PH_INTEGRATE = 2;
  localparam int PH_COUNT     = PH_INTEGRATE + 1;

endpackage

// File: rtl/y_bus_mux.sv
// Combinational N-way select of the client Y-SRAM buses onto the memory port.
// When valid is low the memory sees parked idle values and no write.
module y_bus_mux
  import y_sram_pkg::*;
#(
  parameter int NUM_PHASES = PH_COUNT,
  parameter int ADDR_W     = Y_ADDR_W,
  parameter int DATA_W     = Y_DATA_W,
  parameter int PH_W       = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
  input  logic [PH_W-1:0]              sel,
  input  logic                         valid,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_rd_addr1,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_rd_addr2,
  input  logic [NUM_PHASES-1:0]        cl_we,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_wr_addr,
  input  logic [NUM_PHASES*DATA_W-1:0] cl_wr_data,
  output logic [ADDR_W-1:0]            y_rd_addr1,
  output logic [ADDR_W-1:0]            y_rd_addr2,
  output logic                         y_we,
  output logic [ADDR_W-1:0]            y_wr_addr,
  output logic [DATA_W-1:0]            y_wr_data
);

  // Route only the selected client; everything else stays parked
  always_comb begin
    y_rd_addr1 = IDLE_ADDR;
    y_rd_addr2 = IDLE_ADDR;
    y_we       = 1'b0;
    y_wr_addr  = IDLE_ADDR;
    y_wr_data  = '0;
    if (valid) begin
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (sel == PH_W'(i)) begin
          y_rd_addr1 = cl_rd_addr1[i*ADDR_W +: ADDR_W];
          y_rd_addr2 = cl_rd_addr2[i*ADDR_W +: ADDR_W];
          y_we       = cl_we[i];
          y_wr_addr  = cl_wr_addr[i*ADDR_W +: ADDR_W];
          y_wr_data  = cl_wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/y_phase_arbiter.sv
// Phase sequencer and Y-SRAM bus arbiter for the Jacobi solver top level.
// Enables one client phase at a time, inserts a one-cycle bus turnaround
// between phases, repeats the sequence num_iters times and flags stray dones.
module y_phase_arbiter
  import y_sram_pkg::*;
#(
  parameter int NUM_PHASES = PH_COUNT,
  parameter int ADDR_W     = Y_ADDR_W,
  parameter int DATA_W     = Y_DATA_W,
  parameter int ITER_W     = 8,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ITER_W-1:0]            num_iters,
  input  logic [NUM_PHASES-1:0]        phase_done,
  output logic [NUM_PHASES-1:0]        phase_enable,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_rd_addr1,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_rd_addr2,
  input  logic [NUM_PHASES-1:0]        cl_we,
  input  logic [NUM_PHASES*ADDR_W-1:0] cl_wr_addr,
  input  logic [NUM_PHASES*DATA_W-1:0] cl_wr_data,
  output logic [ADDR_W-1:0]            y_rd_addr1,
  output logic [ADDR_W-1:0]            y_rd_addr2,
  output logic                         y_we,
  output logic [ADDR_W-1:0]            y_wr_addr,
  output logic [DATA_W-1:0]            y_wr_data,
  output logic                         busy,
  output logic [ITER_W-1:0]            iter_count,
  output logic                         all_done,
  output logic                         stray_done
);

  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  state_e                  state_q,        state_d;
  logic [PH_W-1:0]         phase_idx_q,    phase_idx_d;
  logic [ITER_W-1:0]       num_iters_q,    num_iters_d;
  logic [ITER_W-1:0]       iter_count_q,   iter_count_d;
  logic [NUM_PHASES-1:0]   phase_enable_q, phase_enable_d;
  logic                    busy_q,         busy_d;
  logic                    all_done_q,     all_done_d;
  logic                    stray_done_q,   stray_done_d;

  logic [NUM_PHASES-1:0]   active_mask;
  logic                    start_acc;
  logic                    active_done;
  logic                    stray_now;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d        = state_q;
    phase_idx_d    = phase_idx_q;
    num_iters_d    = num_iters_q;
    iter_count_d   = iter_count_q;

    active_mask = (state_q == ST_RUN) ? (NUM_PHASES'(1) << phase_idx_q) : '0;
    active_done = |(phase_done & active_mask);
    stray_now   = |(phase_done & ~active_mask);
    // abort beats a simultaneous start
    start_acc   = (state_q == ST_IDLE) && start && !abort;

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          num_iters_d  = num_iters;
          iter_count_d = '0;
          phase_idx_d  = '0;
          state_d      = (num_iters != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (abort)            state_d = ST_IDLE;
        else if (active_done) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (phase_idx_q != LAST_PH) begin
          phase_idx_d = phase_idx_q + PH_W'(1);
          state_d     = ST_RUN;
        end else begin
          iter_count_d = iter_count_q + ITER_W'(1);
          if (iter_count_d == num_iters_q) begin
            state_d = ST_FIN;
          end else begin
            phase_idx_d = '0;
            state_d     = ST_RUN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    phase_enable_d = (state_d == ST_RUN) ? (NUM_PHASES'(1) << phase_idx_d) : '0;
    // busy covers the completion pulse cycle so all_done is never seen while idle
    busy_d         = (state_d != ST_IDLE) || (state_q == ST_FIN);
    all_done_d     = (state_q == ST_FIN);
    stray_done_d   = (start_acc ? 1'b0 : stray_done_q) | stray_now;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      phase_idx_q    <= '0;
      num_iters_q    <= '0;
      iter_count_q   <= '0;
      phase_enable_q <= '0;
      busy_q         <= 1'b0;
      all_done_q     <= 1'b0;
      stray_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_idx_q    <= phase_idx_d;
      num_iters_q    <= num_iters_d;
      iter_count_q   <= iter_count_d;
      phase_enable_q <= phase_enable_d;
      busy_q         <= busy_d;
      all_done_q     <= all_done_d;
      stray_done_q   <= stray_done_d;
    end
  end

  assign phase_enable = phase_enable_q;
  assign busy         = busy_q;
  assign iter_count   = iter_count_q;
  assign all_done     = all_done_q;
  assign stray_done   = stray_done_q;

  y_bus_mux #(
    .NUM_PHASES (NUM_PHASES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .PH_W       (PH_W),
    .IDLE_ADDR  (IDLE_ADDR)
  ) u_bus_mux (
    .sel         (phase_idx_q),
    .valid       (state_q == ST_RUN),
    .cl_rd_addr1 (cl_rd_addr1),
    .cl_rd_addr2 (cl_rd_addr2),
    .cl_we       (cl_we),
    .cl_wr_addr  (cl_wr_addr),
    .cl_wr_data  (cl_wr_data),
    .y_rd_addr1  (y_rd_addr1),
    .y_rd_addr2  (y_rd_addr2),
    .y_we        (y_we),
    .y_wr_addr   (y_wr_addr),
    .y_wr_data   (y_wr_data)
  );

endmodule
